vga_timing: RTL and testbench



---
 rtl/vga_timing_if.sv | 76 +++++++
 rtl/vga_timing.sv | 197 +++++++++++++++++++
 tb/tb_vga_timing.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
//
// Purpose : bundles the raster outputs of vga_timing. The timing generator
//           drives them through the master modport. The pixel-colour logic
//           and the DAC pins read them through the slave modport.
//
// Signals : pix_tick     - high on the last clk of each pixel period
//           pixel_x      - horizontal counter, 0..H_TOTAL-1
//           pixel_y      - vertical counter, 0..V_TOTAL-1
//           pixel_valid  - pixel is inside the visible area
//           line_start   - one-clk pulse when a new line begins (on wrap)
//           frame_start  - one-clk pulse when a new frame begins (on wrap)
//           vga_clk      - pixel clock to the DAC; rises mid-pixel
//           vga_hs       - horizontal sync, active-low
//           vga_vs       - vertical sync, active-low
//           vga_blank_n  - DAC blank, same as pixel_valid
//           vga_sync_n   - DAC sync-on-green, held at 0
//           frame_cnt    - frame counter; exists only when
//                          VGA_TIMING_FRAME_CNT_EN is defined
//
// The bundle has no handshake. Every signal is a free-running registered
// level or pulse that changes only on the rising edge of clk. Consumers
// sample it whenever they need it. There is no valid/ready pairing and no
// back-pressure.
// ---------------------------------------------------------------------------
interface vga_timing_if;
   logic        pix_tick;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        pixel_valid;
   logic        line_start;
   logic        frame_start;
   logic        vga_clk;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic        vga_sync_n;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   modport master (
`ifdef VGA_TIMING_FRAME_CNT_EN
      output frame_cnt,
`endif
      output pix_tick,
      output pixel_x,
      output pixel_y,
      output pixel_valid,
      output line_start,
      output frame_start,
      output vga_clk,
      output vga_hs,
      output vga_vs,
      output vga_blank_n,
      output vga_sync_n
   );

   modport slave (
`ifdef VGA_TIMING_FRAME_CNT_EN
      input  frame_cnt,
`endif
      input  pix_tick,
      input  pixel_x,
      input  pixel_y,
      input  pixel_valid,
      input  line_start,
      input  frame_start,
      input  vga_clk,
      input  vga_hs,
      input  vga_vs,
      input  vga_blank_n,
      input  vga_sync_n
   );
endinterface

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Purpose : VGA raster timing generator. It divides clk into a pixel strobe,
//           runs the horizontal and vertical counters, and decodes the sync,
//           blank and DAC clock outputs plus the line/frame markers. The
//           default parameters give 640x480@60 from a 50 MHz clk.
//
// Ports   : clk  - system clock
//           rst  - asynchronous, active-high reset
//           vif  - vga_timing_if.master, carrying all raster outputs
//
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt
//           output. It increments together with frame_start and wraps
//           0xFFFF -> 0x0000.
//
// Constraints on parameters: CLK_DIV must be even and >= 2. H_TOTAL and
// V_TOTAL must each be <= 1024, because the coordinates are 10 bits wide.
//
// Every output is a flop. Each flop loads a value decoded from the
// *next-state* counters. As a result, sync, blank and the markers line up
// with the pixel_x/pixel_y of the same cycle, with no pipeline skew.
// ---------------------------------------------------------------------------
module vga_timing #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clk,
   input  logic        rst,
   vga_timing_if.master vif
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

   // The decode bounds are 11 bits wide. When the back porch is zero, the
   // end of sync can equal a total of exactly 1024, and that value does
   // not fit in the 10-bit counters.
   localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
   localparam logic [10:0] HS_BEGIN   = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
   localparam logic [10:0] VS_BEGIN   = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_q,   div_d;
   logic [9:0]       hcnt_q,  hcnt_d;
   logic [9:0]       vcnt_q,  vcnt_d;

   // Registered outputs
   logic             pix_tick_q,    pix_tick_d;
   logic             pixel_valid_q, pixel_valid_d;
   logic             line_start_q,  line_start_d;
   logic             frame_start_q, frame_start_d;
   logic             vga_clk_q,     vga_clk_d;
   logic             hs_q,          hs_d;
   logic             vs_q,          vs_d;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0]      frame_cnt_q,   frame_cnt_d;
`endif

   // Intermediate strobes for this cycle
   logic             tick_now;   // current clk is the last one of the pixel
   logic             h_wrap;     // this tick ends the line
   logic             v_wrap;     // this tick ends the frame

   // ------------------------------------------------------------------
   // Counter next-state
   // ------------------------------------------------------------------
   always_comb begin
      tick_now = (div_q == DIV_LAST);
      h_wrap   = tick_now && (hcnt_q == H_LAST);
      v_wrap   = h_wrap && (vcnt_q == V_LAST);

      div_d = tick_now ? '0 : div_q + 1'b1;

      hcnt_d = hcnt_q;
      if (tick_now) begin
         hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
      end

      // The vertical counter steps only on the horizontal wrap. vga_vs is
      // decoded from vcnt_d, so it switches on whole-line boundaries.
      vcnt_d = vcnt_q;
      if (h_wrap) begin
         vcnt_d = v_wrap ? 10'd0 : vcnt_q + 10'd1;
      end
   end

   // ------------------------------------------------------------------
   // Output decode from the next-state counters
   // ------------------------------------------------------------------
   always_comb begin
      pix_tick_d    = (div_d == DIV_LAST);
      vga_clk_d     = (div_d >= DIV_HALF);
      pixel_valid_d = ({1'b0, hcnt_d} < H_VIS_END) &&
                      ({1'b0, vcnt_d} < V_VIS_END);
      hs_d          = !(({1'b0, hcnt_d} >= HS_BEGIN) &&
                        ({1'b0, hcnt_d} <  HS_END));
      vs_d          = !(({1'b0, vcnt_d} >= VS_BEGIN) &&
                        ({1'b0, vcnt_d} <  VS_END));

      // The markers come from the wrap strobes, not from "counter == 0".
      // This way they cannot fire in the first pixel after reset, and they
      // stay one clk wide for any CLK_DIV.
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + 16'd1;   // wraps 0xFFFF -> 0x0000 naturally
      end
   end
`endif

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         hcnt_q        <= 10'd0;
         vcnt_q        <= 10'd0;
         pix_tick_q    <= 1'b0;
         // (0,0) is a visible pixel, so the reset values of blank and
         // sync already match the coordinate.
         pixel_valid_q <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         vga_clk_q     <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
      end else begin
         div_q         <= div_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         pix_tick_q    <= pix_tick_d;
         pixel_valid_q <= pixel_valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         vga_clk_q     <= vga_clk_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign vif.frame_cnt = frame_cnt_q;
`endif

   // ------------------------------------------------------------------
   // Output mapping
   // ------------------------------------------------------------------
   assign vif.pix_tick    = pix_tick_q;
   assign vif.pixel_x     = hcnt_q;
   assign vif.pixel_y     = vcnt_q;
   assign vif.pixel_valid = pixel_valid_q;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;
   assign vif.vga_clk     = vga_clk_q;
   assign vif.vga_hs      = hs_q;
   assign vif.vga_vs      = vs_q;
   assign vif.vga_blank_n = pixel_valid_q;
   assign vif.vga_sync_n  = 1'b0;   // no sync-on-green

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// Self-checking bench for vga_timing. It uses a reduced raster so that
// whole frames fit in a short run:
//   CLK_DIV=4, H: 8 visible + 2 front + 3 sync + 2 back = 15 pixels,
//   V: 4 visible + 1 front + 2 sync + 1 back = 8 lines.
// From these, one line is 60 clk and one frame is 480 clk.
//
// After each reset release, every cycle is compared against a reference
// derived from the number of clk edges n since release:
//   div = n % 4, pixel p = n / 4, x = p % 15, y = (p / 15) % 8.
// On top of that per-cycle check, the bench compares hand-computed
// constants for the first marker timings and the per-line and per-frame
// sync/blank widths.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing;

   localparam int CLK_DIV = 4;
   localparam int H_TOT   = 15;
   localparam int V_TOT   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vga_timing_if vif();

   vga_timing #(
      .CLK_DIV  (CLK_DIV),
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vif(vif)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   int          exp_fc   = 0;   // expected frame_cnt, tracked from frame_start expectations

   // Statistics collected over one run_cycles call, measured from the DUT.
   int first_ls, first_fs, ls_count, fs_count;
   int hs_low_line0, hs_first_low, vs_low_frame0, vs_first_low;
   int valid_frame0, tick_frame0, vclk_high_frame0, ls_adjacent;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] got);
      logic [31:0] e;
      e = exp_q.pop_front();
      chk(tag, got, e);
   endtask

   // Compare every output against the edge-count reference for edge n.
   task automatic chk_model(input int n);
      int  d, p, h, v;
      bit  e_ls, e_fs, e_valid;
      d = n % CLK_DIV;
      p = n / CLK_DIV;
      h = p % H_TOT;
      v = (p / H_TOT) % V_TOT;
      e_ls    = (n > 0) && (d == 0) && (h == 0);
      e_fs    = e_ls && (v == 0);
      e_valid = (h < 8) && (v < 4);
      if (e_fs) exp_fc++;
      chk($sformatf("pixel_x@%0d", n),     32'(vif.pixel_x),     32'(h));
      chk($sformatf("pixel_y@%0d", n),     32'(vif.pixel_y),     32'(v));
      chk($sformatf("pix_tick@%0d", n),    32'(vif.pix_tick),    32'(d == CLK_DIV - 1));
      chk($sformatf("vga_clk@%0d", n),     32'(vif.vga_clk),     32'(d >= CLK_DIV / 2));
      chk($sformatf("valid@%0d", n),       32'(vif.pixel_valid), 32'(e_valid));
      chk($sformatf("blank_n@%0d", n),     32'(vif.vga_blank_n), 32'(e_valid));
      chk($sformatf("hs@%0d", n),          32'(vif.vga_hs),      32'(!(h >= 10 && h < 13)));
      chk($sformatf("vs@%0d", n),          32'(vif.vga_vs),      32'(!(v >= 5 && v < 7)));
      chk($sformatf("line_start@%0d", n),  32'(vif.line_start),  32'(e_ls));
      chk($sformatf("frame_start@%0d", n), 32'(vif.frame_start), 32'(e_fs));
      chk($sformatf("sync_n@%0d", n),      32'(vif.vga_sync_n),  32'(0));
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk($sformatf("frame_cnt@%0d", n),   32'(vif.frame_cnt),   32'(exp_fc & 16'hFFFF));
`endif
   endtask

   // Call this at a negedge with rst just released. The call samples edge 0
   // (the current values), then ncyc further edges, always at the negedge.
   task automatic run_cycles(input int ncyc);
      logic prev_ls;
      first_ls = -1; first_fs = -1; ls_count = 0; fs_count = 0;
      hs_low_line0 = 0; hs_first_low = -1; vs_low_frame0 = 0; vs_first_low = -1;
      valid_frame0 = 0; tick_frame0 = 0; vclk_high_frame0 = 0; ls_adjacent = 0;
      prev_ls = 1'b0;
      exp_fc = 0;
      for (int n = 0; n <= ncyc; n++) begin
         if (n > 0) begin
            @(posedge clk);
            @(negedge clk);
         end
         chk_model(n);
         if (vif.line_start === 1'b1) begin
            ls_count++;
            if (first_ls < 0) first_ls = n;
            if (prev_ls) ls_adjacent++;
         end
         if (vif.frame_start === 1'b1) begin
            fs_count++;
            if (first_fs < 0) first_fs = n;
         end
         prev_ls = vif.line_start;
         if (n < 60 && vif.vga_hs === 1'b0) begin
            hs_low_line0++;
            if (hs_first_low < 0) hs_first_low = n;
         end
         if (n < 480) begin
            if (vif.vga_vs === 1'b0) begin
               vs_low_frame0++;
               if (vs_first_low < 0) vs_first_low = n;
            end
            if (vif.pixel_valid === 1'b1) valid_frame0++;
            if (vif.pix_tick === 1'b1)    tick_frame0++;
            if (vif.vga_clk === 1'b1)     vclk_high_frame0++;
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      bit found;

      // Step 1: reset state while rst is held.
      repeat (3) @(negedge clk);
      exp_fc = 0;
      chk_model(0);

      // Step 2: release, then run two frames plus a little extra.
      rst = 1'b0;
      run_cycles(1000);

      // Hand-computed raster figures for the reduced geometry.
      exp_q.push_back(32'd60);    // first line_start: 15 px * 4 clk
      exp_q.push_back(32'd480);   // first frame_start: 8 lines * 60 clk
      exp_q.push_back(32'd16);    // line_start pulses in edges 1..1000
      exp_q.push_back(32'd2);     // frame_start pulses in edges 1..1000
      exp_q.push_back(32'd12);    // hs low clk per line: 3 px * 4
      exp_q.push_back(32'd40);    // hs goes low when pixel_x becomes 10
      exp_q.push_back(32'd120);   // vs low clk per frame: 2 lines * 60
      exp_q.push_back(32'd300);   // vs goes low when pixel_y becomes 5
      exp_q.push_back(32'd128);   // valid clk per frame: 8*4 px * 4 clk
      exp_q.push_back(32'd120);   // pix_tick pulses per frame: 15*8
      exp_q.push_back(32'd240);   // vga_clk high half of every pixel
      exp_q.push_back(32'd0);     // line_start never two clk in a row
      pop_chk("first_line_start",  32'(first_ls));
      pop_chk("first_frame_start", 32'(first_fs));
      pop_chk("line_start_count",  32'(ls_count));
      pop_chk("frame_start_count", 32'(fs_count));
      pop_chk("hs_low_width",      32'(hs_low_line0));
      pop_chk("hs_first_low",      32'(hs_first_low));
      pop_chk("vs_low_width",      32'(vs_low_frame0));
      pop_chk("vs_first_low",      32'(vs_first_low));
      pop_chk("valid_clk_count",   32'(valid_frame0));
      pop_chk("pix_tick_count",    32'(tick_frame0));
      pop_chk("vga_clk_high",      32'(vclk_high_frame0));
      pop_chk("line_start_width",  32'(ls_adjacent));

      // Step 3: reset in the middle of a frame, at pixel (5,2).
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (vif.pixel_x == 10'd5 && vif.pixel_y == 10'd2) found = 1'b1;
      end
      chk("wait_mid_frame", 32'(found), 32'(1));
      #2 rst = 1'b1;
      #1;
      exp_fc = 0;
      chk_model(0);    // values return to reset immediately, with no clk edge
      repeat (3) @(negedge clk);
      chk_model(0);    // values stay at reset while rst is held
      rst = 1'b0;
      run_cycles(500);
      chk("restart_first_line",  32'(first_ls), 32'd60);
      chk("restart_first_frame", 32'(first_fs), 32'd480);

`ifdef VGA_TIMING_FRAME_CNT_EN
      // Step 4: preload the counter to 0xFFFF. Check that it wraps to 0 at
      // the next frame_start.
      @(negedge clk);
      force dut.frame_cnt_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.frame_cnt_q;
      chk("frame_cnt_preload", 32'(vif.frame_cnt), 32'h0000FFFF);
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (vif.frame_start === 1'b1) found = 1'b1;
      end
      chk("wait_frame_start", 32'(found), 32'(1));
      chk("frame_cnt_wrap", 32'(vif.frame_cnt), 32'h00000000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
